// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_pkg
// Description : Shared definitions for the program counter / return-address
//               stack block: default geometry, the one-hot-free operation
//               encoding and the strobe priority encoder.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_pkg;

  // Default geometry; modules derive their own widths from their parameters.
  localparam int PC_WIDTH_DEF = 16;
  localparam int DEPTH_DEF    = 8;
  localparam int SP_W         = $clog2(DEPTH_DEF);

  // Operation selected for the current cycle.
  typedef enum logic [2:0] {
    OP_HOLD  = 3'd0,
    OP_INC   = 3'd1,
    OP_RET   = 3'd2,
    OP_CALL  = 3'd3,
    OP_LOAD  = 3'd4,
    OP_RESET = 3'd5
  } pc_op_e;

  // Strobe priority: reset > load > call > ret > inc > hold.
  function automatic pc_op_e pc_decode(input logic reset,
                                       input logic load,
                                       input logic call,
                                       input logic ret,
                                       input logic inc);
    pc_op_e op;
    op = OP_HOLD;
    if (reset)     op = OP_RESET;
    else if (load) op = OP_LOAD;
    else if (call) op = OP_CALL;
    else if (ret)  op = OP_RET;
    else if (inc)  op = OP_INC;
    return op;
  endfunction

endpackage : pc_pkg
`default_nettype wire

// File: rtl/pc_ras.sv
`default_nettype none
// ============================================================================
// Module      : pc_ras
// Description : Circular return-address stack. DEPTH x WIDTH register file
//               with a wrapping stack pointer and a separate fill counter.
//               A push while full overwrites the oldest entry (the caller
//               decides whether that is allowed).
// Ports       : clk, reset   - clock, synchronous active-high reset
//               push, wdata  - write wdata at sp, advance sp
//               pop          - retreat sp when not empty
//               top          - entry at sp-1 (most recent push)
//               depth        - valid entries 0..DEPTH
//               full, empty  - decoded from depth
// Revision    : 1.0 - initial release
// ============================================================================
module pc_ras
  import pc_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           top,
  output logic [$clog2(DEPTH):0]     depth,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_sp;
  logic [DW-1:0]    r_depth;
  logic             w_full;
  logic             w_empty;

  assign w_full  = (r_depth == DW'(DEPTH));
  assign w_empty = (r_depth == '0);

  // Entry contents are don't-care after reset; only sp/depth are cleared.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      r_mem[r_sp] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sp    <= '0;
      r_depth <= '0;
    end else if (push) begin
      // sp wraps naturally; when full the oldest slot is being reused so
      // the fill count saturates at DEPTH.
      r_sp <= r_sp + AW'(1);
      if (!w_full) begin
        r_depth <= r_depth + DW'(1);
      end
    end else if (pop && !w_empty) begin
      r_sp    <= r_sp - AW'(1);
      r_depth <= r_depth - DW'(1);
    end
  end

  assign top   = r_mem[r_sp - AW'(1)];
  assign depth = r_depth;
  assign full  = w_full;
  assign empty = w_empty;

endmodule : pc_ras
`default_nettype wire

// File: rtl/pc_call_stack.sv
`default_nettype none
// ============================================================================
// Module      : pc_call_stack
// Description : Program counter with integrated return-address stack.
//               Supports reset / load / call / ret / inc / hold, one per
//               cycle, highest priority wins. out is registered; there is no
//               combinational path from in to out.
// Ports       : clk, reset          - clock, synchronous active-high reset
//               load, call, ret, inc- operation strobes
//               in                  - jump / call target
//               out                 - current PC
//               depth, empty, full  - stack fill status
//               err_ovf, err_unf    - sticky errors (PC_STACK_ERR_EN only)
// Config      : `define PC_STACK_ERR_EN to reject call-when-full and
//               ret-when-empty and flag them on sticky error outputs.
//               Without it, call-when-full overwrites the oldest entry.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_call_stack
  import pc_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic                    call,
  input  logic                    ret,
  input  logic                    inc,
  input  logic [WIDTH-1:0]        in,
  output logic [WIDTH-1:0]        out,
  output logic [$clog2(DEPTH):0]  depth,
  output logic                    empty,
  output logic                    full
`ifdef PC_STACK_ERR_EN
  ,
  output logic                    err_ovf,
  output logic                    err_unf
`endif
);

  logic [WIDTH-1:0]        r_pc;
  logic [WIDTH-1:0]        w_pc_next;
  logic [WIDTH-1:0]        w_pc_plus1;
  logic [WIDTH-1:0]        w_top;
  logic [$clog2(DEPTH):0]  w_depth;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_push;
  logic                    w_pop;
  pc_op_e                  w_op;

  assign w_op       = pc_decode(reset, load, call, ret, inc);
  // Return address and increment share one adder; wraps modulo 2^WIDTH.
  assign w_pc_plus1 = r_pc + WIDTH'(1);

  always_comb begin
    w_pc_next = r_pc;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    case (w_op)
      OP_RESET: w_pc_next = '0;
      OP_LOAD:  w_pc_next = in;
      OP_CALL: begin
`ifdef PC_STACK_ERR_EN
        if (!w_full) begin
          w_push    = 1'b1;
          w_pc_next = in;
        end
`else
        // Full stack: the RAS overwrites its oldest entry.
        w_push    = 1'b1;
        w_pc_next = in;
`endif
      end
      OP_RET: begin
        if (!w_empty) begin
          w_pop     = 1'b1;
          w_pc_next = w_top;
        end
      end
      OP_INC:   w_pc_next = w_pc_plus1;
      default:  w_pc_next = r_pc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= '0;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  pc_ras #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ras (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .wdata (w_pc_plus1),
    .top   (w_top),
    .depth (w_depth),
    .full  (w_full),
    .empty (w_empty)
  );

`ifdef PC_STACK_ERR_EN
  logic r_err_ovf;
  logic r_err_unf;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_err_ovf <= 1'b0;
      r_err_unf <= 1'b0;
    end else begin
      if (w_op == OP_CALL && w_full) r_err_ovf <= 1'b1;
      if (w_op == OP_RET && w_empty) r_err_unf <= 1'b1;
    end
  end

  assign err_ovf = r_err_ovf;
  assign err_unf = r_err_unf;
`endif

  assign out   = r_pc;
  assign depth = w_depth;
  assign empty = w_empty;
  assign full  = w_full;

endmodule : pc_call_stack
`default_nettype wire

// File: tb/tb_pc_call_stack.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_call_stack
// Description : Self-checking bench for pc_call_stack (WIDTH=16, DEPTH=8).
//               Directed scenarios followed by random strobes, all compared
//               against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_call_stack;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;

  logic              clk;
  logic              reset, load, call, ret, inc;
  logic [WIDTH-1:0]  in;
  logic [WIDTH-1:0]  out;
  logic [3:0]        depth;
  logic              empty, full;
`ifdef PC_STACK_ERR_EN
  logic              err_ovf, err_unf;
`endif

  pc_call_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .call    (call),
    .ret     (ret),
    .inc     (inc),
    .in      (in),
    .out     (out),
    .depth   (depth),
    .empty   (empty),
    .full    (full)
`ifdef PC_STACK_ERR_EN
    ,
    .err_ovf (err_ovf),
    .err_unf (err_unf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [WIDTH-1:0] m_pc;
  logic [WIDTH-1:0] m_stk[$];
  logic             m_ovf, m_unf;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic r, input logic l, input logic c,
                       input logic rt, input logic i, input logic [WIDTH-1:0] d);
    if (r) begin
      m_pc = '0;
      m_stk.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (l) begin
      m_pc = d;
    end else if (c) begin
      if (m_stk.size() == DEPTH) begin
`ifdef PC_STACK_ERR_EN
        m_ovf = 1'b1;
`else
        void'(m_stk.pop_front());
        m_stk.push_back(m_pc + 16'd1);
        m_pc = d;
`endif
      end else begin
        m_stk.push_back(m_pc + 16'd1);
        m_pc = d;
      end
    end else if (rt) begin
      if (m_stk.size() == 0) m_unf = 1'b1;
      else m_pc = m_stk.pop_back();
    end else if (i) begin
      m_pc = m_pc + 16'd1;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".out"},   32'(out),   32'(m_pc));
    chk({tag, ".depth"}, 32'(depth), 32'(m_stk.size()));
    chk({tag, ".empty"}, 32'(empty), 32'(m_stk.size() == 0));
    chk({tag, ".full"},  32'(full),  32'(m_stk.size() == DEPTH));
`ifdef PC_STACK_ERR_EN
    chk({tag, ".ovf"},   32'(err_ovf), 32'(m_ovf));
    chk({tag, ".unf"},   32'(err_unf), 32'(m_unf));
`endif
  endtask

  // Apply one cycle of strobes, advance the model, check 1 time unit later.
  task automatic step(input string tag, input logic r, input logic l, input logic c,
                      input logic rt, input logic i, input logic [WIDTH-1:0] d);
    @(negedge clk);
    reset = r; load = l; call = c; ret = rt; inc = i; in = d;
    @(posedge clk);
    model(r, l, c, rt, i, d);
    #1;
    check_all(tag);
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; call = 1'b0; ret = 1'b0; inc = 1'b0; in = '0;
    m_pc = '0; m_ovf = 1'b0; m_unf = 1'b0;

    step("reset", 1, 0, 0, 0, 0, 16'h0000);
    chk("reset.out_lit", 32'(out), 32'h0);

    for (int k = 0; k < 3; k++) step("inc", 0, 0, 0, 0, 1, 16'h0000);
    chk("inc3.out_lit", 32'(out), 32'h3);

    step("loadFFFF", 0, 1, 0, 0, 0, 16'hFFFF);
    step("incwrap", 0, 0, 0, 0, 1, 16'h0000);
    chk("incwrap.out_lit", 32'(out), 32'h0);

    step("load_inc", 0, 1, 0, 0, 1, 16'h0100);
    chk("load_inc.out_lit", 32'(out), 32'h0100);

    step("load10", 0, 1, 0, 0, 0, 16'h0010);
    step("call200", 0, 0, 1, 0, 0, 16'h0200);
    chk("call200.out_lit", 32'(out), 32'h0200);
    chk("call200.depth_lit", 32'(depth), 32'd1);
    step("inc_in_sub", 0, 0, 0, 0, 1, 16'h0000);
    step("ret", 0, 0, 0, 1, 0, 16'h0000);
    chk("ret.out_lit", 32'(out), 32'h0011);
    chk("ret.empty_lit", 32'(empty), 32'd1);

    // Fill the stack from distinct PCs, then one more call.
    for (int k = 0; k < DEPTH; k++) step("fill", 0, 0, 1, 0, 0, 16'(16'h1000 + k * 16'h10));
    chk("fill.full_lit", 32'(full), 32'd1);
    step("call9", 0, 0, 1, 0, 0, 16'h2000);
    for (int k = 0; k < DEPTH; k++) step("unwind", 0, 0, 0, 1, 0, 16'h0000);
    step("ret_empty", 0, 0, 0, 1, 0, 16'h0000);
    chk("ret_empty.depth_lit", 32'(depth), 32'd0);

    step("reset_clear", 1, 0, 0, 0, 0, 16'h0000);
    step("load_a5", 0, 1, 0, 0, 0, 16'h00A5);
    step("call_ret", 0, 0, 1, 1, 0, 16'h0300);
    chk("call_ret.out_lit", 32'(out), 32'h0300);
    step("reset_call", 1, 0, 1, 0, 0, 16'h0400);
    chk("reset_call.out_lit", 32'(out), 32'h0);
    chk("reset_call.depth_lit", 32'(depth), 32'd0);

    // Random strobes; reset kept rare so the stack gets exercised deeply.
    for (int n = 0; n < 3000; n++) begin
      logic r, l, c, rt, i;
      r  = ($urandom_range(0, 99) == 0);
      l  = ($urandom_range(0, 9) == 0);
      c  = ($urandom_range(0, 2) == 0);
      rt = ($urandom_range(0, 2) == 0);
      i  = ($urandom_range(0, 1) == 0);
      step("rand", r, l, c, rt, i, 16'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_pc_call_stack
`default_nettype wire
